// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the store write-select stage and the UART transmitter
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_W-1:0] level_nxt;
  logic pop, push_ok, drop, overflow_nxt;
  assign full = level == CNT_W'(DEPTH);
  assign empty = level == '0;
  assign tx_valid = !empty;
  assign tx_data = mem[rd_ptr];
  // A full queue still takes a push when the head leaves the same cycle; flush overrides all traffic
  always_comb begin
    pop = tx_valid && tx_ready;
    push_ok = wr_en && (!full || pop);
    drop = wr_en && full && !pop;
    rd_ptr_nxt = flush ? '0 : rd_ptr + PW'(pop);
    wr_ptr_nxt = flush ? '0 : wr_ptr + PW'(push_ok);
    level_nxt = flush ? '0 : level + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_nxt = drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
  end
  // Pointer, occupancy and sticky overflow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      level <= level_nxt;
      overflow <= overflow_nxt;
    end
  end
  // Storage array; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-model check of uart_tx_fifo with directed and random traffic
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic wr_en = 0;
  logic [WIDTH-1:0] wr_data = '0;
  logic flush = 0;
  logic ovf_clr = 0;
  logic tx_ready = 0;
  logic tx_valid, full, empty, overflow;
  logic [WIDTH-1:0] tx_data;
  logic [CNT_W-1:0] level;
  int vectors = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];
  bit m_ovf = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .ovf_clr(ovf_clr), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) assert (level <= CNT_W'(DEPTH));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f, input logic c);
    bit pop, drop;
    @(negedge clk);
    wr_en = w; wr_data = d; tx_ready = r; flush = f; ovf_clr = c;
    @(posedge clk);
    pop = q.size() != 0 && r;
    drop = w && q.size() == DEPTH && !pop;
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (w && !drop) q.push_back(d);
    end
    m_ovf = drop ? 1'b1 : c ? 1'b0 : m_ovf;
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    wr_en = 1; wr_data = 8'h41;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    wr_en = 0;
    rst_n = 1;
    idle(3);
    chk("idle_data", 32'(tx_data), 0);

    step(1, 8'h55, 0, 0, 0);
    chk("lat_valid", 32'(tx_valid), 1);
    chk("lat_data", 32'(tx_data), 32'h55);
    idle(5);
    chk("hold_data", 32'(tx_data), 32'h55);
    step(0, 8'h00, 1, 0, 0);
    chk("pop_empty", 32'(empty), 1);

    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 0, 0, 0);
      chk("fill_level", 32'(level), DEPTH);
      chk("fill_ovf", 32'(overflow), 1);
      for (int i = 0; i < DEPTH; i++) begin
        chk("drain_order", 32'(tx_data), 32'(i));
        step(0, 8'h00, 1, 0, 0);
      end
      chk("drain_empty", 32'(empty), 1);
    end

    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    chk("pp_level", 32'(level), DEPTH);
    chk("pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp_order", 32'(tx_data), i == DEPTH - 1 ? 32'hAA : 32'(8'h11 + i));
      step(0, 8'h00, 1, 0, 0);
    end

    for (int i = 0; i < DEPTH + 1; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    while (level > 3) step(0, 8'h00, 1, 0, 0);
    step(1, 8'hBB, 1, 1, 0);
    chk("fl_level", 32'(level), 0);
    chk("fl_valid", 32'(tx_valid), 0);
    chk("fl_ovf", 32'(overflow), 1);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
    step(1, 8'hCC, 0, 0, 1);
    chk("clr_prio", 32'(overflow), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_alone", 32'(overflow), 0);

    step(0, 8'h00, 1, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    q.delete(); m_ovf = 0;
    chk("arst_level", 32'(level), 0);
    chk("arst_valid", 32'(tx_valid), 0);
    @(negedge clk);
    rst_n = 1;
    idle(2);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
